// File: rtl/muxuns_lane_scheduler_pkg.sv
// Shared definitions for the lane scheduler: default word width, FSM state
// encoding and the width helper used to size pointers and counters.
package muxuns_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        WAIT0 = 1'b0,
        WAIT1 = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/muxuns_lane_scheduler_if.sv
// Lane inputs, output handshake and status flags of the lane scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface muxuns_lane_scheduler_if #(
    parameter int DATA_W = muxuns_pkg::DEF_DATA_W
);
    logic [DATA_W-1:0] lane_in0;
    logic              valid_in0;
    logic [DATA_W-1:0] lane_in1;
    logic              valid_in1;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              sel;
    logic              full0;
    logic              full1;
    logic              overflow;
    logic              order_err;

    modport master (
        output lane_in0, valid_in0, lane_in1, valid_in1, ready_out,
        input  data_out, valid_out, sel, full0, full1, overflow, order_err
    );

    modport slave (
        input  lane_in0, valid_in0, lane_in1, valid_in1, ready_out,
        output data_out, valid_out, sel, full0, full1, overflow, order_err
    );
endinterface

// File: rtl/muxuns_lane_scheduler_fifo.sv
// Per-lane FIFO: small register array with asynchronous clear. Pushes are
// ignored while full, pops while empty; full is registered from the next count.
module uns_lane_fifo
    import muxuns_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              full_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the array is cleared on reset too; it is only a few flops and reset must discard buffered words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/muxuns_lane_scheduler.sv
// Merges two striped lanes back into one in-order stream: alternating pops,
// registered valid/ready output, and a resync skip when the expected lane starves.
module muxuns_lane_scheduler
    import muxuns_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic reset,
    muxuns_lane_scheduler_if.slave bus
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              pop0, pop1;
    logic              slot_free;
    logic [DATA_W-1:0] dout0, dout1;
    logic [CNT_W-1:0]  count0, count1;
    logic              full0, full1, empty0, empty1;

    uns_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push(bus.valid_in0), .din(bus.lane_in0),
        .pop(pop0), .dout(dout0), .count(count0), .full(full0), .empty(empty0)
    );

    uns_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push(bus.valid_in1), .din(bus.lane_in1),
        .pop(pop1), .dout(dout1), .count(count1), .full(full1), .empty(empty1)
    );

    assign slot_free = !valid_q || bus.ready_out;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q && !bus.ready_out;
        err_d   = err_q;
        pop0    = 1'b0;
        pop1    = 1'b0;
        unique case (state_q)
            WAIT0: begin
                if (!empty0 && slot_free) begin
                    pop0    = 1'b1;
                    data_d  = dout0;
                    valid_d = 1'b1;
                    state_d = WAIT1;
                end else if (empty0 && full1) begin
                    // Lane 0 starved while lane 1 backs up: skip to regain order.
                    err_d   = 1'b1;
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (!empty1 && slot_free) begin
                    pop1    = 1'b1;
                    data_d  = dout1;
                    valid_d = 1'b1;
                    state_d = WAIT0;
                end else if (empty1 && full0) begin
                    err_d   = 1'b1;
                    state_d = WAIT0;
                end
            end
        endcase
        // A word offered to a full lane is dropped by the FIFO; remember it.
        ovf_d = ovf_q
              || (bus.valid_in0 && (count0 == CNT_W'(DEPTH)))
              || (bus.valid_in1 && (count1 == CNT_W'(DEPTH)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.sel       = (state_q == WAIT1);
    assign bus.full0     = full0;
    assign bus.full1     = full1;
    assign bus.overflow  = ovf_q;
    assign bus.order_err = err_q;

endmodule
